// File: rtl/boxhead_pio_pkg.sv
// Shared register offsets, edge-mode codes and write payload for the BoxHead PIO port.
package boxhead_pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] PIO_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] PIO_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] PIO_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] PIO_EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] PIO_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] PIO_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_NONE = 0;
    localparam int unsigned EDGE_RISE = 1;
    localparam int unsigned EDGE_FALL = 2;
    localparam int unsigned EDGE_ANY  = 3;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  data;
    } pio_wr_t;

endpackage

// File: rtl/boxhead_pio_edge_detect.sv
// Input synchroniser, one-cycle history and per-bit edge events, held off
// until the synchroniser has flushed its reset zeros.
module boxhead_pio_edge_detect
    import boxhead_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_evt_c
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] ARM_CNT = CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_prev;
    logic [CNT_W-1:0]                  warm_cnt;
    logic                              armed;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;
    logic [WIDTH-1:0]                  raw_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            in_prev <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            in_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // Saturating post-reset counter; edges are ignored until it arms.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (warm_cnt != ARM_CNT) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
        end
    end

    assign armed   = (warm_cnt == ARM_CNT);
    assign in_sync = sync_q[SYNC_STAGES-1];
    assign rise    = in_sync & ~in_prev;
    assign fall    = ~in_sync & in_prev;

    always_comb begin
        raw_evt = '0;
        case (EDGE_TYPE)
            EDGE_RISE: raw_evt = rise;
            EDGE_FALL: raw_evt = fall;
            EDGE_ANY:  raw_evt = rise | fall;
            default:   raw_evt = '0;
        endcase
    end

    assign edge_evt_c = armed ? raw_evt : '0;

endmodule

// File: rtl/boxhead_soc_pio_gen.sv
// Avalon-MM s1 general-purpose I/O slave: register file, edge capture,
// maskable level interrupt and zero-wait-state read mux.
module boxhead_soc_pio_gen
    import boxhead_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe,
    output logic              irq
);

    pio_wr_t          wr_c;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_val;

    boxhead_pio_edge_detect #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .in_sync   (in_sync),
        .edge_evt_c(edge_evt)
    );

    assign wr_c.en   = chipselect && !write_n;
    assign wr_c.addr = address;
    assign wr_c.data = writedata;
    assign wd        = wr_c.data[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            dir      <= DIR_RESET;
            irqmask  <= '0;
        end else if (wr_c.en) begin
            case (wr_c.addr)
                PIO_DATA:    data_out <= wd;
                PIO_DIR:     dir      <= wd;
                PIO_IRQMASK: irqmask  <= wd;
                PIO_OUTSET:  data_out <= data_out | wd;
                PIO_OUTCLR:  data_out <= data_out & ~wd;
                default:     ;
            endcase
        end
    end

    // A new event outranks a same-cycle write-1-to-clear on that bit.
    assign cap_clr = (wr_c.en && wr_c.addr == PIO_EDGECAP) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | edge_evt;
        end
    end

    always_comb begin
        rd_val = '0;
        case (address)
            PIO_DATA:    rd_val = (dir & data_out) | (~dir & in_sync);
            PIO_DIR:     rd_val = dir;
            PIO_IRQMASK: rd_val = irqmask;
            PIO_EDGECAP: rd_val = edgecap;
            default:     rd_val = '0;
        endcase
    end

    assign readdata = BUS_W'(rd_val);
    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_boxhead_soc_pio_gen.sv
// Directed bench for the PIO port: stimulus queues expected observations,
// a negedge monitor pops and compares them.
module tb_boxhead_soc_pio_gen;
    import boxhead_pio_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    boxhead_soc_pio_gen #(
        .WIDTH      (W),
        .OUT_RESET  (4'hA),
        .DIR_RESET  (4'hF),
        .EDGE_TYPE  (EDGE_RISE),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef enum int {K_RD, K_OUT, K_OE, K_IRQ} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input kind_t k, input logic [31:0] e, input string n);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        sbq.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        writedata  = 32'h0;
        push_exp(K_RD, e, n);
        step();
    endtask

    // Monitor: everything queued during a cycle is observed mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                chk_t        c;
                logic [31:0] act;
                c = sbq.pop_front();
                case (c.kind)
                    K_RD:    act = readdata;
                    K_OUT:   act = 32'(out_port);
                    K_OE:    act = 32'(oe);
                    default: act = 32'(irq);
                endcase
                total++;
                if (act !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        in_port = '0;
        idle();
        step();

        // Reset state
        push_exp(K_OUT, 32'hA, "rst_out");
        push_exp(K_OE,  32'hF, "rst_oe");
        push_exp(K_IRQ, 32'h0, "rst_irq");
        rd(PIO_DATA,    32'hA, "rst_rd_data");
        rd(PIO_DIR,     32'hF, "rst_rd_dir");
        rd(PIO_IRQMASK, 32'h0, "rst_rd_irqmask");
        rd(PIO_EDGECAP, 32'h0, "rst_rd_edgecap");

        reset_n = 1'b1;
        idle();
        repeat (4) step();

        // Data, atomic set and clear
        wr(PIO_DATA, 32'h5);
        step();
        push_exp(K_OUT, 32'h5, "out_data5");
        wr(PIO_OUTSET, 32'h8);
        step();
        push_exp(K_OUT, 32'hD, "out_set8");
        wr(PIO_OUTCLR, 32'h1);
        step();
        push_exp(K_OUT, 32'hC, "out_clr1");
        rd(PIO_OUTSET, 32'h0, "rd_outset_zero");
        rd(PIO_OUTCLR, 32'h0, "rd_outclr_zero");
        rd(3'd6, 32'h0, "rd_addr6_zero");
        rd(3'd7, 32'h0, "rd_addr7_zero");
        rd(PIO_DATA, 32'hC, "rd_data_all_out");

        // Mixed direction: inputs on bits 3:2 through the synchroniser
        wr(PIO_DIR, 32'h3);
        step();
        wr(PIO_DATA, 32'h1);
        in_port = 4'b1100;
        push_exp(K_OE, 32'h3, "oe_dir3");
        step();
        rd(PIO_DATA, 32'h1, "rd_data_presync");
        rd(PIO_DATA, 32'hD, "rd_data_sync");
        push_exp(K_IRQ, 32'h0, "irq_unmasked");
        rd(PIO_EDGECAP, 32'hC, "edgecap_rise23");
        wr(PIO_EDGECAP, 32'hF);
        step();
        rd(PIO_EDGECAP, 32'h0, "edgecap_clr_all");

        // Falling edges are not captured in rising mode
        in_port = 4'b0000;
        idle();
        repeat (4) step();
        rd(PIO_EDGECAP, 32'h0, "edgecap_fall_none");

        // Rising edge on bit 2 with exact capture latency and irq
        wr(PIO_IRQMASK, 32'h4);
        step();
        rd(PIO_IRQMASK, 32'h4, "rd_irqmask4");
        in_port = 4'b0100;
        idle();
        step();
        step();
        push_exp(K_IRQ, 32'h0, "irq_before_cap");
        rd(PIO_EDGECAP, 32'h0, "edgecap_before_cap");
        push_exp(K_IRQ, 32'h1, "irq_bit2");
        rd(PIO_EDGECAP, 32'h4, "edgecap_bit2");
        wr(PIO_EDGECAP, 32'h4);
        push_exp(K_IRQ, 32'h1, "irq_during_clr");
        step();
        idle();
        push_exp(K_IRQ, 32'h0, "irq_after_clr");
        rd(PIO_EDGECAP, 32'h0, "edgecap_clr_bit2");

        // Set beats same-cycle clear on bit 0
        in_port = 4'b0101;
        idle();
        step();
        step();
        wr(PIO_EDGECAP, 32'h1);
        step();
        idle();
        rd(PIO_EDGECAP, 32'h1, "edgecap_set_wins");
        wr(PIO_IRQMASK, 32'h1);
        step();
        push_exp(K_IRQ, 32'h1, "irq_bit0");
        rd(PIO_IRQMASK, 32'h1, "rd_irqmask1");

        // Bits above WIDTH ignored
        wr(PIO_DATA, 32'hFFFF_FFF0);
        step();
        push_exp(K_OUT, 32'h0, "out_hi_ignored");
        rd(PIO_DATA, 32'h4, "rd_data_hi_ignored");

        // Asynchronous reset in the middle of a write
        wr(PIO_DATA, 32'h6);
        #2;
        reset_n = 1'b0;
        #1;
        push_exp(K_OUT, 32'hA, "async_rst_out");
        push_exp(K_OE,  32'hF, "async_rst_oe");
        push_exp(K_IRQ, 32'h0, "async_rst_irq");
        step();
        idle();
        reset_n = 1'b1;
        push_exp(K_OUT, 32'hA, "post_rst_out");
        step();
        rd(PIO_DATA,    32'hA, "post_rst_rd_data");
        rd(PIO_IRQMASK, 32'h0, "post_rst_rd_irqmask");
        repeat (3) step();
        rd(PIO_EDGECAP, 32'h0, "edgecap_post_rst_quiet");

        idle();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
